stall_ctrl: RTL and testbench

//  Central pipeline freeze sequencer for the 5-stage core. Merges stall requests from ID (load-use),
//  EX (multi-cycle mul/div) and MEM (data SRAM wait) into the shared `StallBus consumed by the
//  IF/ID/EX/MEM/WB pipeline registers. Owns the multi-cycle-op FSM and counter that hold EX for a fixed duration.

---
 rtl/stall_ctrl_pkg.sv | 30 +++
 rtl/stall_md_seq.sv | 50 +++++
 rtl/stall_ctrl.sv | 62 ++++++
 tb/tb_stall_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - shared stall bus encodings, FSM state codes and priority merge
package stall_ctrl_pkg;

    typedef logic [5:0] stall_bus_t;

    localparam stall_bus_t STALL_NONE  = 6'b000000;
    localparam stall_bus_t STALL_LDUSE = 6'b000111;
    localparam stall_bus_t STALL_EX    = 6'b001111;
    localparam stall_bus_t STALL_MEM   = 6'b011111;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_BUSY = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    // MEM freezes everything up to WB input, so it outranks the EX hold and the ID bubble.
    function automatic stall_bus_t stall_merge(input logic mem_req, input logic ex_req,
                                               input logic id_req);
        stall_bus_t v;
        if (mem_req)
            v = STALL_MEM;
        else if (ex_req)
            v = STALL_EX;
        else if (id_req)
            v = STALL_LDUSE;
        else
            v = STALL_NONE;
        return v;
    endfunction

endpackage

// File: rtl/stall_md_seq.sv
// rtl/stall_md_seq.sv - multi-cycle mul/div hold sequencer (FSM + 6-bit down counter)
module stall_md_seq
    import stall_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic hold,
    output logic ex_hold,
    output logic busy,
    output logic done
);

    logic [1:0] r_state;
    logic [5:0] r_cnt;

    // A MEM stall freezes the sequencer so the hold window is never eaten by the memory wait.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= MD_IDLE;
            r_cnt   <= 6'd0;
        end else if (!hold) begin
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        r_cnt   <= 6'(MD_CYCLES - 1);
                        r_state <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (r_cnt == 6'd1)
                        r_state <= MD_DONE;
                    else
                        r_cnt <= r_cnt - 6'd1;
                end
                MD_DONE: r_state <= MD_IDLE;
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    always_comb begin
        ex_hold = rst & (((r_state == MD_IDLE) & start) | (r_state == MD_BUSY));
        busy    = rst & ((r_state == MD_BUSY) | (r_state == MD_DONE));
        done    = rst & (r_state == MD_DONE) & ~hold;
    end

endmodule

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall merge and perf counters; STALL_CTRL_PERF_EN enables counters
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stallreq,
    input  logic        ex_md_start,
    input  logic        mem_stallreq,
    output logic [5:0]  stall,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] perf_ld_cnt,
    output logic [31:0] perf_md_cnt
);

    logic w_ex_hold;

    stall_md_seq #(
        .MD_CYCLES(MD_CYCLES)
    ) u_md_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (ex_md_start),
        .hold   (mem_stallreq),
        .ex_hold(w_ex_hold),
        .busy   (md_busy),
        .done   (md_done)
    );

    always_comb begin
        stall = STALL_NONE;
        if (rst)
            stall = stall_merge(mem_stallreq, w_ex_hold, id_stallreq);
    end

`ifdef STALL_CTRL_PERF_EN
    logic [31:0] r_perf_ld;
    logic [31:0] r_perf_md;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_ld <= 32'd0;
            r_perf_md <= 32'd0;
        end else begin
            if (stall == STALL_LDUSE && r_perf_ld != 32'hFFFF_FFFF)
                r_perf_ld <= r_perf_ld + 32'd1;
            if (stall == STALL_EX && r_perf_md != 32'hFFFF_FFFF)
                r_perf_md <= r_perf_md + 32'd1;
        end
    end

    assign perf_ld_cnt = r_perf_ld;
    assign perf_md_cnt = r_perf_md;
`else
    assign perf_ld_cnt = 32'd0;
    assign perf_md_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - directed self-checking bench for stall_ctrl with MD_CYCLES=4
module tb_stall_ctrl;

`ifdef STALL_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] S0  = 6'b000000;
    localparam logic [5:0] SLD = 6'b000111;
    localparam logic [5:0] SEX = 6'b001111;
    localparam logic [5:0] SME = 6'b011111;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stallreq;
    logic        ex_md_start;
    logic        mem_stallreq;
    logic [5:0]  stall;
    logic        md_busy;
    logic        md_done;
    logic [31:0] perf_ld_cnt;
    logic [31:0] perf_md_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stall_ctrl #(
        .MD_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_stallreq (id_stallreq),
        .ex_md_start (ex_md_start),
        .mem_stallreq(mem_stallreq),
        .stall       (stall),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .perf_ld_cnt (perf_ld_cnt),
        .perf_md_cnt (perf_md_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, check combinational outputs at the falling edge.
    task automatic step(input string tag, input logic v_rst, input logic v_id,
                        input logic v_ex, input logic v_mem, input logic [5:0] e_stall,
                        input logic e_busy, input logic e_done);
        rst          = v_rst;
        id_stallreq  = v_id;
        ex_md_start  = v_ex;
        mem_stallreq = v_mem;
        @(negedge clk);
        chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
        chk({tag, ".busy"}, 32'(md_busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(md_done), 32'(e_done));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset with each request pulsed
        step("rst0", 1'b0, 1'b1, 1'b0, 1'b0, S0, 1'b0, 1'b0);
        step("rst1", 1'b0, 1'b0, 1'b1, 1'b0, S0, 1'b0, 1'b0);
        step("rst2", 1'b0, 1'b0, 1'b0, 1'b1, S0, 1'b0, 1'b0);
        chk("rst.perf_ld", perf_ld_cnt, 32'd0);
        chk("rst.perf_md", perf_md_cnt, 32'd0);
        step("idle0", 1'b1, 1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0);

        // 2: single load-use cycle
        step("ld0", 1'b1, 1'b1, 1'b0, 1'b0, SLD, 1'b0, 1'b0);
        step("ld1", 1'b1, 1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0);
        chk("ld.perf_ld", perf_ld_cnt, PERF ? 32'd1 : 32'd0);

        // 3: plain 4-cycle op
        step("md_t0", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b0, 1'b0);
        step("md_t1", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("md_t2", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("md_t3", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("md_t4", 1'b1, 1'b0, 1'b1, 1'b0, S0, 1'b1, 1'b1);

        // 4: back-to-back start, MEM stall on cycles 2-3 of the op
        step("mm_t0", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b0, 1'b0);
        step("mm_t1", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("mm_t2", 1'b1, 1'b0, 1'b1, 1'b1, SME, 1'b1, 1'b0);
        step("mm_t3", 1'b1, 1'b0, 1'b1, 1'b1, SME, 1'b1, 1'b0);
        step("mm_t4", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("mm_t5", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("mm_t6", 1'b1, 1'b0, 1'b1, 1'b0, S0, 1'b1, 1'b1);
        step("mm_t7", 1'b1, 1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0);

        // 4b: MEM stall on the DONE cycle delays the single done pulse
        step("md_a0", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b0, 1'b0);
        step("md_a1", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("md_a2", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("md_a3", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("md_a4", 1'b1, 1'b0, 1'b1, 1'b1, SME, 1'b1, 1'b0);
        step("md_a5", 1'b1, 1'b0, 1'b1, 1'b0, S0, 1'b1, 1'b1);
        step("md_a6", 1'b1, 1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0);

        // 5: priority with simultaneous requests; start blocked while MEM stalls
        step("pr_m", 1'b1, 1'b1, 1'b1, 1'b1, SME, 1'b0, 1'b0);
        step("pr_e", 1'b1, 1'b1, 1'b1, 1'b0, SEX, 1'b0, 1'b0);
        step("pr_b1", 1'b1, 1'b1, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("pr_b2", 1'b1, 1'b1, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("pr_b3", 1'b1, 1'b1, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("pr_d", 1'b1, 1'b0, 1'b1, 1'b0, S0, 1'b1, 1'b1);
        step("pr_i", 1'b1, 1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0);
        chk("pr.perf_ld", perf_ld_cnt, PERF ? 32'd1 : 32'd0);
        chk("pr.perf_md", perf_md_cnt, PERF ? 32'd16 : 32'd0);

        // 6: reset mid-op abandons it; a fresh start gets the full hold
        step("ra_t0", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b0, 1'b0);
        step("ra_t1", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("ra_r", 1'b0, 1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0);
        step("ra_i", 1'b1, 1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0);
        step("ra_s0", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b0, 1'b0);
        step("ra_s1", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("ra_s2", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("ra_s3", 1'b1, 1'b0, 1'b1, 1'b0, SEX, 1'b1, 1'b0);
        step("ra_s4", 1'b1, 1'b0, 1'b1, 1'b0, S0, 1'b1, 1'b1);
        step("ra_s5", 1'b1, 1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0);
        chk("ra.perf_ld", perf_ld_cnt, 32'd0);
        chk("ra.perf_md", perf_md_cnt, PERF ? 32'd4 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
